// File: rtl/audio_pkg.sv
// audio_pkg -- constants and types shared by the audio record and playback engines.
//   ADDR_W      : SDRAM word address width
//   DATA_W      : sample / SDRAM word width
//   HDR_OFS     : offset of the first data word from the slot base (the header sits at base)
//   MAX_LEN_DEF : default maximum sample count per recording
//   rec_state_t : record engine state encoding (also exported on the debug port)
package audio_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] HDR_OFS     = 23'd1;
  localparam logic [ADDR_W-1:0] MAX_LEN_DEF = 23'h7F_FFFE;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_SAMPLE  = 2'd1,
    ST_WRITE_DATA   = 2'd2,
    ST_WRITE_LENGTH = 2'd3
  } rec_state_t;

endpackage

// File: rtl/record_core.sv
// record_core -- audio capture engine. Accepts stereo samples over a valid/ready
// handshake, writes each to SDRAM at base+1, base+2, ... through a single-request
// write port, and on stop (or when MAX_LEN samples are captured) writes the sample
// count as a header word at the slot base so playback can find the slot length.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   rec_start           start pulse (IDLE only); rec_select gives the slot base
//   rec_pause           pause capture (only with RECORD_PAUSE_EN defined)
//   rec_stop            end recording and commit the header
//   rec_done            one-cycle pulse after the header write completes
//   rec_length          sample count of the last committed recording
//   rec_write/rec_addr/rec_writedata  SDRAM write request, held until rec_sdram_finished
//   rec_sdram_finished  one-cycle completion pulse from the arbiter
//   rec_audio_valid/rec_audio_data/rec_audio_ready  audio-in handshake
//   debug               current state encoding
//
// Build option: define RECORD_PAUSE_EN to make rec_pause gate sample acceptance.
module record_core #(
  parameter int                     ADDR_W  = audio_pkg::ADDR_W,
  parameter int                     DATA_W  = audio_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]      MAX_LEN = audio_pkg::MAX_LEN_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              rec_start,
  input  logic [ADDR_W-1:0] rec_select,
  input  logic              rec_pause,
  input  logic              rec_stop,
  output logic              rec_done,
  output logic [ADDR_W-1:0] rec_length,
  output logic              rec_write,
  output logic [ADDR_W-1:0] rec_addr,
  output logic [DATA_W-1:0] rec_writedata,
  input  logic              rec_sdram_finished,
  input  logic              rec_audio_valid,
  input  logic [DATA_W-1:0] rec_audio_data,
  output logic              rec_audio_ready,
  output logic [1:0]        debug
);

  import audio_pkg::*;

  rec_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [DATA_W-1:0] sample_reg, sample_next;
  logic              stop_pending_reg, stop_pending_next;
  logic [ADDR_W-1:0] length_reg, length_next;
  logic              done_reg, done_next;

  logic              pause_gate;
  logic              at_max;
  logic [ADDR_W-1:0] count_inc;

`ifdef RECORD_PAUSE_EN
  assign pause_gate = rec_pause;
`else
  logic unused_pause;
  assign pause_gate   = 1'b0;
  assign unused_pause = rec_pause;
`endif

  assign at_max    = (count_reg == MAX_LEN);
  assign count_inc = count_reg + 1'b1;

  // Ready drops combinationally on stop/limit so that a stop always beats a
  // simultaneous valid: the sample presented that cycle is never accepted.
  assign rec_audio_ready = (state_reg == ST_WAIT_SAMPLE) && !rec_stop && !at_max && !pause_gate;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg        <= ST_IDLE;
      base_reg         <= '0;
      addr_reg         <= '0;
      count_reg        <= '0;
      sample_reg       <= '0;
      stop_pending_reg <= 1'b0;
      length_reg       <= '0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      base_reg         <= base_next;
      addr_reg         <= addr_next;
      count_reg        <= count_next;
      sample_reg       <= sample_next;
      stop_pending_reg <= stop_pending_next;
      length_reg       <= length_next;
      done_reg         <= done_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    base_next         = base_reg;
    addr_next         = addr_reg;
    count_next        = count_reg;
    sample_next       = sample_reg;
    stop_pending_next = stop_pending_reg;
    length_next       = length_reg;
    done_next         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Start wins over a coincident stop; stop alone is ignored here.
        if (rec_start) begin
          base_next         = rec_select;
          addr_next         = rec_select + HDR_OFS;
          count_next        = '0;
          stop_pending_next = 1'b0;
          state_next        = ST_WAIT_SAMPLE;
        end
      end

      ST_WAIT_SAMPLE: begin
        if (rec_stop || at_max) begin
          state_next = ST_WRITE_LENGTH;
        end else if (rec_audio_valid && rec_audio_ready) begin
          sample_next = rec_audio_data;
          state_next  = ST_WRITE_DATA;
        end
      end

      ST_WRITE_DATA: begin
        // A stop here is remembered; the in-flight write always completes.
        if (rec_stop) begin
          stop_pending_next = 1'b1;
        end
        if (rec_sdram_finished) begin
          addr_next  = addr_reg + 1'b1;
          count_next = count_inc;
          if (stop_pending_reg || rec_stop || (count_inc == MAX_LEN)) begin
            state_next = ST_WRITE_LENGTH;
          end else begin
            state_next = ST_WAIT_SAMPLE;
          end
        end
      end

      ST_WRITE_LENGTH: begin
        if (rec_sdram_finished) begin
          length_next       = count_reg;
          done_next         = 1'b1;
          stop_pending_next = 1'b0;
          state_next        = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Request address/data are decoded from state so they are exactly stable for
  // the whole time a request is held, and are zero whenever no request is up.
  always_comb begin
    rec_write     = 1'b0;
    rec_addr      = '0;
    rec_writedata = '0;
    case (state_reg)
      ST_WRITE_DATA: begin
        rec_write     = 1'b1;
        rec_addr      = addr_reg;
        rec_writedata = sample_reg;
      end
      ST_WRITE_LENGTH: begin
        rec_write     = 1'b1;
        rec_addr      = base_reg;
        rec_writedata = DATA_W'(count_reg);
      end
      default: begin
        rec_write     = 1'b0;
        rec_addr      = '0;
        rec_writedata = '0;
      end
    endcase
  end

  assign rec_done   = done_reg;
  assign rec_length = length_reg;
  assign debug      = state_reg;

endmodule

// File: tb/tb_record_core.sv
// tb_record_core -- directed bench for record_core. Expected SDRAM writes are
// pushed to a queue when samples are offered/stop is issued and popped by the
// SDRAM responder when the DUT's write completes. MAX_LEN is set to 4 so the
// automatic termination can be reached quickly.
module tb_record_core;

  localparam int AW = 23;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          rec_start;
  logic [AW-1:0] rec_select;
  logic          rec_pause;
  logic          rec_stop;
  logic          rec_done;
  logic [AW-1:0] rec_length;
  logic          rec_write;
  logic [AW-1:0] rec_addr;
  logic [DW-1:0] rec_writedata;
  logic          rec_sdram_finished;
  logic          rec_audio_valid;
  logic [DW-1:0] rec_audio_data;
  logic          rec_audio_ready;
  logic [1:0]    debug;

  record_core #(.ADDR_W(AW), .DATA_W(DW), .MAX_LEN(23'd4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .rec_start(rec_start), .rec_select(rec_select),
    .rec_pause(rec_pause), .rec_stop(rec_stop),
    .rec_done(rec_done), .rec_length(rec_length),
    .rec_write(rec_write), .rec_addr(rec_addr), .rec_writedata(rec_writedata),
    .rec_sdram_finished(rec_sdram_finished),
    .rec_audio_valid(rec_audio_valid), .rec_audio_data(rec_audio_data),
    .rec_audio_ready(rec_audio_ready), .debug(debug)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            pass_cnt  = 0;
  int            total_cnt = 0;
  int            lat       = 0;
  int            wait_cnt  = 0;
  logic [AW-1:0] exp_base;
  logic [AW-1:0] exp_addr;
  logic [AW-1:0] exp_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // SDRAM responder: completes each held request after 'lat' extra cycles and
  // checks it against the oldest expected write.
  always @(negedge i_clk) begin
    wr_t e;
    rec_sdram_finished = 1'b0;
    if (rec_write === 1'b1) begin
      if (wait_cnt >= lat) begin
        wait_cnt = 0;
        rec_sdram_finished = 1'b1;
        if (exp_q.size() == 0) begin
          check("write_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          $display("write addr=0x%0h data=0x%0h (expect 0x%0h/0x%0h)", rec_addr, rec_writedata, e.addr, e.data);
          check("wr_addr", 64'(rec_addr), 64'(e.addr));
          check("wr_data", 64'(rec_writedata), 64'(e.data));
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic do_start(input logic [AW-1:0] b);
    @(negedge i_clk);
    rec_start  = 1'b1;
    rec_select = b;
    exp_base   = b;
    exp_addr   = b + 23'd1;
    exp_cnt    = '0;
    @(negedge i_clk);
    rec_start = 1'b0;
    check("state_after_start", 64'(debug), 64'd1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit  got;
    wr_t e;
    got = 1'b0;
    @(negedge i_clk);
    rec_audio_valid = 1'b1;
    rec_audio_data  = d;
    for (int i = 0; i < 60 && !got; i++) begin
      if (rec_audio_ready) begin
        e.addr = exp_addr;
        e.data = d;
        exp_q.push_back(e);
        exp_addr = exp_addr + 23'd1;
        exp_cnt  = exp_cnt + 23'd1;
        got = 1'b1;
      end
      @(negedge i_clk);
    end
    rec_audio_valid = 1'b0;
    $display("sample 0x%0h offered, accepted=%0d", d, got);
    if (!got) check("sample_accepted", 64'd0, 64'd1);
  endtask

  task automatic push_header();
    wr_t e;
    e.addr = exp_base;
    e.data = DW'(exp_cnt);
    exp_q.push_back(e);
  endtask

  task automatic do_stop();
    @(negedge i_clk);
    push_header();
    rec_stop = 1'b1;
    @(negedge i_clk);
    rec_stop = 1'b0;
  endtask

  task automatic wait_done(input logic [AW-1:0] len);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge i_clk);
      if (rec_done) got = 1'b1;
    end
    $display("recording done=%0d length=%0d (expect %0d)", got, rec_length, len);
    check("done_seen", 64'(got), 64'd1);
    if (got) begin
      check("rec_length", 64'(rec_length), 64'(len));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("debug_idle", 64'(debug), 64'd0);
      @(negedge i_clk);
      check("done_one_cycle", 64'(rec_done), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_rdy;
    bit any_wr;
    i_rst = 1'b1;
    rec_start = 1'b0; rec_select = '0; rec_pause = 1'b0; rec_stop = 1'b0;
    rec_audio_valid = 1'b0; rec_audio_data = '0;
    exp_base = '0; exp_addr = '0; exp_cnt = '0;
    #1;
    check("rst_write", 64'(rec_write), 64'd0);
    check("rst_ready", 64'(rec_audio_ready), 64'd0);
    check("rst_done",  64'(rec_done), 64'd0);
    check("rst_debug", 64'(debug), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_ready", 64'(rec_audio_ready), 64'd0);

    // 1: three samples then stop
    lat = 0;
    do_start(23'h100);
    check("wait_ready", 64'(rec_audio_ready), 64'd1);
    send(32'hA); send(32'hB); send(32'hC);
    do_stop();
    wait_done(23'd3);

    // 2: stop while a slow data write is in flight
    lat = 5;
    do_start(23'h180);
    send(32'h11);
    check("t2_state_write_data", 64'(debug), 64'd2);
    check("t2_ready_low", 64'(rec_audio_ready), 64'd0);
    do_stop();
    check("t2_write_held", 64'(rec_write), 64'd1);
    wait_done(23'd1);

    // 3: stop right after start
    lat = 0;
    do_start(23'h040);
    do_stop();
    wait_done(23'd0);

    // 4: automatic termination at MAX_LEN=4
    lat = 1;
    do_start(23'h300);
    send(32'h31); send(32'h32); send(32'h33); send(32'h34);
    push_header();
    wait_done(23'd4);

    // 5: reset during a data write
    lat = 20;
    do_start(23'h050);
    send(32'h77);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("mid_rst_write", 64'(rec_write), 64'd0);
    check("mid_rst_addr",  64'(rec_addr), 64'd0);
    check("mid_rst_wdata", 64'(rec_writedata), 64'd0);
    check("mid_rst_length", 64'(rec_length), 64'd0);
    check("mid_rst_debug", 64'(debug), 64'd0);
    exp_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    lat = 1;
    do_start(23'h200);
    send(32'h21); send(32'h22);
    do_stop();
    wait_done(23'd2);

    // 6: pause behaviour
    lat = 0;
    do_start(23'h400);
`ifdef RECORD_PAUSE_EN
    any_rdy = 1'b0;
    any_wr  = 1'b0;
    @(negedge i_clk);
    rec_pause = 1'b1;
    rec_audio_valid = 1'b1;
    rec_audio_data  = 32'h99;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (rec_audio_ready) any_rdy = 1'b1;
      if (rec_write) any_wr = 1'b1;
    end
    check("pause_no_ready", 64'(any_rdy), 64'd0);
    check("pause_no_write", 64'(any_wr), 64'd0);
    rec_audio_valid = 1'b0;
    rec_pause = 1'b0;
    send(32'h99); send(32'h9A);
    do_stop();
    wait_done(23'd2);
`else
    any_rdy = 1'b0;
    any_wr  = 1'b0;
    @(negedge i_clk);
    rec_pause = 1'b1;
    @(negedge i_clk);
    check("pause_ignored_ready", 64'(rec_audio_ready), 64'd1);
    send(32'h55);
    rec_pause = 1'b0;
    do_stop();
    wait_done(23'd1);
`endif

    // start and stop together in IDLE: start wins
    @(negedge i_clk);
    rec_start = 1'b1; rec_stop = 1'b1; rec_select = 23'h500;
    @(negedge i_clk);
    rec_start = 1'b0; rec_stop = 1'b0;
    check("start_beats_stop", 64'(debug), 64'd1);
    exp_base = 23'h500; exp_addr = 23'h501; exp_cnt = '0;
    do_stop();
    wait_done(23'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/record_core.md
Name: record_core

Overview:
Capture engine for the audio recording path, and the write-side counterpart of the playback engine. Accepts 32-bit stereo samples from the audio-in interface with a valid/ready handshake and writes them to SDRAM through the shared single-request read/write port. On stop, it writes a length header at the slot base address, so the playback engine can later read the slot back. Sits between the top-level controller, the SDRAM arbiter port and the audio codec receiver.

Parameters:
ADDR_W, 23, SDRAM word address width
DATA_W, 32, sample / SDRAM word width
MAX_LEN, 23'h7F_FFFE, maximum samples per recording; recording auto-terminates when this count is reached

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
rec_start  in  1  start recording; pulse, sampled in IDLE only
rec_select  in  ADDR_W  slot base address; header word goes here, data follows from base+1
rec_pause  in  1  pause capture (effective only with RECORD_PAUSE_EN)
rec_stop  in  1  end recording and commit header
rec_done  out  1  one-cycle pulse when the header write completes
rec_length  out  ADDR_W  sample count of the last committed recording
rec_write  out  1  SDRAM write request, held until finished
rec_addr  out  ADDR_W  SDRAM word address
rec_writedata  out  DATA_W  SDRAM write data
rec_sdram_finished  in  1  SDRAM write accepted/complete (one-cycle pulse)
rec_audio_valid  in  1  audio-in sample valid
rec_audio_data  in  DATA_W  audio-in sample
rec_audio_ready  out  1  core can accept a sample
debug  out  2  current state encoding

Behaviour:
- Reset (async, immediate, also mid-operation): state=IDLE. rec_write, rec_done and rec_audio_ready are 0. rec_addr, rec_writedata, rec_length and debug are 0. Internal base, count, sample and stop_pending are cleared. No header is written for an interrupted recording.
- States: IDLE=0, WAIT_SAMPLE=1, WRITE_DATA=2, WRITE_LENGTH=3.
- IDLE: on rec_start, latch base=rec_select, set addr=rec_select+1, count=0, then go to WAIT_SAMPLE. rec_stop in IDLE is ignored. When start and stop arrive together, start wins.
- WAIT_SAMPLE:
  - rec_audio_ready=1.
  - On rec_audio_valid&&ready, latch the sample and go to WRITE_DATA. rec_write is asserted on the next cycle, so latency is 1 cycle from acceptance.
  - If rec_stop is high or count==MAX_LEN: ready=0, no sample is accepted that cycle, go to WRITE_LENGTH. Stop takes priority over a simultaneous valid.
- WRITE_DATA:
  - rec_write=1, rec_addr=addr, rec_writedata=sample, all held stable until rec_sdram_finished.
  - rec_audio_ready=0.
  - On finished: addr=addr+1, count=count+1. Go to WRITE_LENGTH if stop_pending or the new count==MAX_LEN, else go to WAIT_SAMPLE.
  - rec_stop during WRITE_DATA sets stop_pending. The in-flight write is never aborted.
- WRITE_LENGTH:
  - rec_write=1, rec_addr=base, rec_writedata={zero-extend, count}.
  - On finished: rec_length=count, rec_done=1 for exactly one cycle, clear stop_pending, return to IDLE.
  - rec_stop here has no further effect.
- Header format: word at base = sample count N. Data occupies base+1..base+N. The playback end address is base+N+1, exclusive.
- Zero-length recording (stop before any sample): header written with 0, rec_length=0.
- Arithmetic: addresses are ADDR_W-bit and wrap modulo 2^ADDR_W. MAX_LEN bounds count so a slot never overruns itself.
- rec_start outside IDLE is ignored. A new start is accepted on the cycle after rec_done.

Optional Feature:
RECORD_PAUSE_EN:
- Defined: rec_pause high in WAIT_SAMPLE forces rec_audio_ready=0, so no sample is accepted. A write already in WRITE_DATA still completes. rec_stop while paused goes to WRITE_LENGTH normally. Count resumes unchanged after unpause.
- Undefined: the rec_pause port exists but is ignored.

Decomposition:
- Shared package audio_pkg:
  - state enum rec_state_t (2-bit)
  - ADDR_W and DATA_W constants
  - header-offset constant HDR_OFS=1
  - MAX_LEN default
  - The playback engine imports the same ADDR_W/HDR_OFS.
- No sub-module needed: a single FSM with counters. Optionally factor sdram_req_hold (holds request/addr/data until finished) if the arbiter interface is reused elsewhere.

Test Plan:
1. Start with rec_select=0x100, feed 3 samples 0xA,0xB,0xC, then stop → writes 0xA@0x101, 0xB@0x102, 0xC@0x103, then 3@0x100; rec_done one cycle; rec_length=3.
2. Stop asserted mid-WRITE_DATA (finished delayed 5 cycles) → data write completes with addr held, then header written; no sample lost or duplicated.
3. Stop immediately after start → single write 0@base; rec_length=0.
4. MAX_LEN=4, continuous valid → after 4 data writes the header 4@base is written automatically, without stop.
5. Reset asserted during WRITE_DATA → all outputs 0 on the same edge; a subsequent start at 0x200 records correctly.
6. RECORD_PAUSE_EN defined, pause for 10 cycles with valid high → ready=0 and no writes during the pause; count continues correctly after release.
